ps_width_multiplier: RTL and testbench
======================================

Name: ps_width_multiplier

Overview:
Widens a PacketStream from WIDTH-bit words to COUNT*WIDTH-bit words by packing COUNT consecutive narrow words into one wide word. It is the inverse of the width divider and is placed on receive paths, ahead of wide-datapath processing.
- The first narrow word received occupies the least-significant slot.
- A packet whose last wide word is only partly filled closes that word early. The number of unused upper slots is reported on o_mty.

Parameters:
WIDTH, 4, width of the input (narrow) data word in bits
COUNT, 8, number of narrow words per output word; COUNT > 1

Ports:
clk    input   1                    clock
reset  input   1                    asynchronous reset, active-high
i_dat  input   WIDTH                narrow input data
i_val  input   1                    input word valid
i_eop  input   1                    input word is last of packet
i_rdy  output  1                    block accepts input word
o_dat  output  COUNT*WIDTH          wide output data; slot k = bits [(k+1)*WIDTH-1 : k*WIDTH]
o_mty  output  $clog2(COUNT)        number of empty upper slots; meaningful only when o_eop=1
o_val  output  1                    output word valid
o_eop  output  1                    output word is last of packet
o_rdy  input   1                    downstream accepts output word

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Every register also has an initial value equal to its reset value.
- Reset values:
  - o_val=0, o_eop=0, o_mty=0, o_dat=0.
  - Slot counter cnt=0; accumulator=0.
  - i_rdy=1 after reset, because it is combinational from o_val.
- Handshake: a transfer occurs on a clock edge where val & rdy.
  - i_rdy = ~o_val | o_rdy. This path is combinational from o_rdy.
  - o_val, o_dat, o_mty and o_eop are registered and stay stable while o_val & ~o_rdy.
- Slot counter cnt: width $clog2(COUNT), range 0..COUNT-1. It counts narrow words held in the accumulator, which is (COUNT-1)*WIDTH bits.
- Input accept, i_val & i_rdy. "Completing" means cnt==COUNT-1 or i_eop=1.
  - Not completing: write i_dat into accumulator slot cnt, then cnt <= cnt+1.
  - Completing, output register update:
    - o_dat <= accumulator slots 0..cnt-1, with i_dat in slot cnt.
    - Slots above cnt follow the Optional Feature.
    - o_mty <= COUNT-1-cnt.
    - o_eop <= i_eop.
    - o_val <= 1.
  - Completing, housekeeping: cnt <= 0, and the accumulator is cleared if zero-pad is enabled.
- Output side:
  - If o_val & o_rdy and no completing accept occurs in the same cycle, then o_val <= 0.
  - A simultaneous output drain and completing accept reloads the output register with no bubble. Sustained throughput is one output word per COUNT input words.
- Latency: o_val rises on the cycle after the completing word is accepted.
- Boundary conditions:
  - When cnt==COUNT-1 and i_eop=1, the word is full: o_mty=0 and o_eop=1.
  - A single-word packet gives o_mty=COUNT-1.
  - cnt wraps from COUNT-1 to 0 only through completion; no other wrap path exists.
  - i_val=0 holds all state.
  - Non-completing words are also stalled while the output register is held (o_val & ~o_rdy). This is accepted by design.
  - o_mty is 0 whenever o_eop=0.
- Reset during operation: a mid-packet reset discards the partial accumulation and any pending output word. The next accepted word starts at slot 0.

Optional Feature:
Macro PS_WIDTH_MULTIPLIER_ZERO_PAD_EN.
- Defined:
  - Unused upper slots of a short final word are driven to 0.
  - The accumulator is cleared on every completion.
- Undefined:
  - Unused slots carry stale accumulator contents and are don't-care.
  - The accumulator is not cleared, which saves logic.
- All other behaviour is identical in both builds.

Test Plan:
All scenarios use WIDTH=4, COUNT=4, with the zero-pad macro defined unless noted.
1. 8 words 1..8 with eop on word 8, o_rdy=1 -> output 16'h4321 (mty=0, eop=0), then 16'h8765 (mty=0, eop=1). Each output is valid one cycle after its 4th word; no input stalls.
2. Words A,B,C with eop on C -> output 16'h0CBA, o_mty=1, o_eop=1.
3. Single word 5 with eop -> output 16'h0005, o_mty=3, o_eop=1. The next packet then starts at slot 0.
4. Backpressure: first output pending and o_rdy=0 for 5 cycles.
   - i_rdy=0 and o_dat/o_mty/o_eop stay stable throughout.
   - Raise o_rdy in the same cycle the next completing word is presented: both transfers occur and o_val stays 1.
5. Reset after words 1 and 2 are accepted, then send 9,A,B,C -> output 16'hCBA9, mty=0. No trace of 1 or 2 appears.
6. Macro undefined: send 1,2,3,4, then 7 with eop.
   - Second output has o_mty=3 and slot 0=7.
   - Bench checks only slot 0; slots 1-3 are not compared.

Source files
------------

// File: rtl/ps_width_multiplier.sv
// ---------------------------------------------------------------------------
// ps_width_multiplier
//
// Packs COUNT consecutive WIDTH-bit PacketStream words into one COUNT*WIDTH-bit
// word. The first narrow word lands in the least-significant slot. A packet
// whose final wide word is only partly filled closes that word early, and the
// number of unused upper slots is reported on o_mty.
//
// Build option:
//   PS_WIDTH_MULTIPLIER_ZERO_PAD_EN
//     defined   : unused upper slots of a short final word read as zero; the
//                 accumulator is cleared on every completion.
//     undefined : unused upper slots carry stale accumulator contents
//                 (don't-care); the accumulator is never cleared.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous reset, active-high
//   i_dat  in   narrow input data (WIDTH)
//   i_val  in   input word valid
//   i_eop  in   input word is last of packet
//   i_rdy  out  block accepts input word (combinational from o_val/o_rdy)
//   o_dat  out  wide output data; slot k = bits [(k+1)*WIDTH-1 : k*WIDTH]
//   o_mty  out  empty upper slots; meaningful only when o_eop=1
//   o_val  out  output word valid
//   o_eop  out  output word is last of packet
//   o_rdy  in   downstream accepts output word
// ---------------------------------------------------------------------------
module ps_width_multiplier #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned COUNT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_val,
    input  logic                     i_eop,
    output logic                     i_rdy,
    output logic [COUNT*WIDTH-1:0]   o_dat,
    output logic [$clog2(COUNT)-1:0] o_mty,
    output logic                     o_val,
    output logic                     o_eop,
    input  logic                     o_rdy
);

    localparam int unsigned CntW = $clog2(COUNT);
    localparam int unsigned AccW = (COUNT - 1) * WIDTH;
    localparam int unsigned OutW = COUNT * WIDTH;
    localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // Slot counter: number of narrow words currently held in the accumulator.
    logic [CntW-1:0] r_cnt = '0;
    // Only COUNT-1 slots are stored; the final slot always comes straight
    // from i_dat on the completing beat.
    logic [AccW-1:0] r_acc = '0;

    logic [OutW-1:0] r_dat = '0;
    logic [CntW-1:0] r_mty = '0;
    logic            r_eop = 1'b0;
    logic            r_val = 1'b0;

    // -----------------------------------------------------------------------
    // Next-state and combinational signals
    // -----------------------------------------------------------------------
    logic            w_rdy;
    logic            w_accept;
    logic            w_complete;
    logic [OutW-1:0] w_acc_ext;
    logic [OutW-1:0] w_wide;

    logic [CntW-1:0] w_cnt_nxt;
    logic [AccW-1:0] w_acc_nxt;
    logic [OutW-1:0] w_dat_nxt;
    logic [CntW-1:0] w_mty_nxt;
    logic            w_eop_nxt;
    logic            w_val_nxt;

    // The output register can take a new word when it is empty or is being
    // drained this cycle, which gives back-to-back wide words with no bubble.
    assign w_rdy      = ~r_val | o_rdy;
    assign w_accept   = i_val & w_rdy;
    assign w_complete = (r_cnt == CntLast) | i_eop;

    // Accumulator padded to full output width so every slot index is in range.
    assign w_acc_ext = {{WIDTH{1'b0}}, r_acc};

    // Assemble the wide word presented on a completing beat.
    always_comb begin
        w_wide = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (k == int'(r_cnt)) begin
                w_wide[k*WIDTH +: WIDTH] = i_dat;
            end else if (k < int'(r_cnt)) begin
                w_wide[k*WIDTH +: WIDTH] = w_acc_ext[k*WIDTH +: WIDTH];
            end else begin
`ifdef PS_WIDTH_MULTIPLIER_ZERO_PAD_EN
                w_wide[k*WIDTH +: WIDTH] = '0;
`else
                // Stale contents: cheaper than masking, and don't-care here.
                w_wide[k*WIDTH +: WIDTH] = w_acc_ext[k*WIDTH +: WIDTH];
`endif
            end
        end
    end

    // Slot counter and accumulator.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_acc_nxt = r_acc;
        if (w_accept) begin
            if (w_complete) begin
                // Completion is the only path back to slot 0.
                w_cnt_nxt = '0;
`ifdef PS_WIDTH_MULTIPLIER_ZERO_PAD_EN
                w_acc_nxt = '0;
`endif
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
                for (int k = 0; k < COUNT - 1; k++) begin
                    if (k == int'(r_cnt)) begin
                        w_acc_nxt[k*WIDTH +: WIDTH] = i_dat;
                    end
                end
            end
        end
    end

    // Output register. A completing accept in the same cycle as a drain
    // reloads the register instead of clearing o_val.
    always_comb begin
        w_dat_nxt = r_dat;
        w_mty_nxt = r_mty;
        w_eop_nxt = r_eop;
        w_val_nxt = r_val;
        if (r_val & o_rdy) begin
            w_val_nxt = 1'b0;
        end
        if (w_accept & w_complete) begin
            w_dat_nxt = w_wide;
            // Non-eop completions always have cnt==COUNT-1, so mty is 0 there.
            w_mty_nxt = CntLast - r_cnt;
            w_eop_nxt = i_eop;
            w_val_nxt = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_dat <= '0;
            r_mty <= '0;
            r_eop <= 1'b0;
            r_val <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_acc <= w_acc_nxt;
            r_dat <= w_dat_nxt;
            r_mty <= w_mty_nxt;
            r_eop <= w_eop_nxt;
            r_val <= w_val_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign i_rdy = w_rdy;
    assign o_dat = r_dat;
    assign o_mty = r_mty;
    assign o_eop = r_eop;
    assign o_val = r_val;

endmodule

// File: tb/tb_ps_width_multiplier.sv
// ---------------------------------------------------------------------------
// tb_ps_width_multiplier
//
// Self-checking bench for ps_width_multiplier with WIDTH=4, COUNT=4.
// Expected wide words are built by a packing model as each narrow word is
// accepted and queued; a monitor pops and compares on every output transfer.
// Upper slots of short words are compared only in the zero-pad build.
// ---------------------------------------------------------------------------
module tb_ps_width_multiplier;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned COUNT = 4;

    typedef struct {
        logic [15:0] dat;
        logic [15:0] mask;
        logic [1:0]  mty;
        logic        eop;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  i_dat;
    logic        i_val;
    logic        i_eop;
    logic        i_rdy;
    logic [15:0] o_dat;
    logic [1:0]  o_mty;
    logic        o_val;
    logic        o_eop;
    logic        o_rdy;

    ps_width_multiplier #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_dat (i_dat),
        .i_val (i_val),
        .i_eop (i_eop),
        .i_rdy (i_rdy),
        .o_dat (o_dat),
        .o_mty (o_mty),
        .o_val (o_val),
        .o_eop (o_eop),
        .o_rdy (o_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    int          m_cnt    = 0;
    logic [15:0] m_word   = '0;
    exp_t        mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packing model: called once per accepted narrow word.
    task automatic model_accept(input logic [3:0] dat, input logic eop);
        exp_t e;
        m_word[m_cnt*4 +: 4] = dat;
        if (m_cnt == COUNT - 1 || eop) begin
            e.mask = '0;
            for (int k = 0; k < COUNT; k++) begin
`ifdef PS_WIDTH_MULTIPLIER_ZERO_PAD_EN
                e.mask[k*4 +: 4] = 4'hF;
`else
                if (k <= m_cnt) e.mask[k*4 +: 4] = 4'hF;
`endif
            end
            e.dat = m_word;
            e.mty = 2'(COUNT - 1 - m_cnt);
            e.eop = eop;
            sb.push_back(e);
            m_word = '0;
            m_cnt  = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Present one word; returns after the accepting edge (+1). Bounded wait.
    task automatic send(input logic [3:0] dat, input logic eop, output int stalls);
        int waited;
        i_dat  = dat;
        i_eop  = eop;
        i_val  = 1'b1;
        stalls = 0;
        waited = 0;
        @(negedge clk);
        while (!i_rdy && waited < 50) begin
            stalls++;
            waited++;
            @(negedge clk);
        end
        if (!i_rdy) begin
            check_eq("send_timeout", 32'(i_rdy), 1);
        end else begin
            model_accept(dat, eop);
            @(posedge clk);
            #1;
        end
        i_val = 1'b0;
        i_eop = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_val = 1'b0;
        i_eop = 1'b0;
        sb.delete();
        m_cnt  = 0;
        m_word = '0;
        @(negedge clk);
        check_eq("rst_o_val", 32'(o_val), 0);
        check_eq("rst_o_dat", 32'(o_dat), 0);
        check_eq("rst_o_mty", 32'(o_mty), 0);
        check_eq("rst_o_eop", 32'(o_eop), 0);
        check_eq("rst_i_rdy", 32'(i_rdy), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every output transfer.
    always @(negedge clk) begin
        if (!reset && o_val) begin
            if (!o_eop) check_eq("mty_zero_mid", 32'(o_mty), 0);
            if (o_rdy) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 32'(sb.size()), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("out_dat", 32'(o_dat & mon_e.mask), 32'(mon_e.dat & mon_e.mask));
                    check_eq("out_mty", 32'(o_mty), 32'(mon_e.mty));
                    check_eq("out_eop", 32'(o_eop), 32'(mon_e.eop));
                end
            end
        end
    end

    initial begin
        int st;
        int st_sum;
        int waited;
        reset = 1'b1;
        i_dat = '0;
        i_val = 1'b0;
        i_eop = 1'b0;
        o_rdy = 1'b1;
        do_reset();

        // 1: two full words, back to back, no stalls, one-cycle latency.
        st_sum = 0;
        for (int w = 1; w <= 8; w++) begin
            send(4'(w), (w == 8), st);
            st_sum += st;
            if (w == 3) check_eq("t1_no_early_val", 32'(o_val), 0);
            if (w == 4 || w == 8) begin
                check_eq("t1_latency", 32'(o_val), 1);
                check_eq("t1_dat", 32'(o_dat), (w == 4) ? 32'h4321 : 32'h8765);
            end
        end
        check_eq("t1_no_stall", 32'(st_sum), 0);
        idle(3);

        // 2: three-word packet.
        send(4'hA, 1'b0, st);
        send(4'hB, 1'b0, st);
        send(4'hC, 1'b1, st);
        check_eq("t2_mty", 32'(o_mty), 1);
        idle(3);

        // 3: single-word packet, then a fresh packet starting at slot 0.
        send(4'h5, 1'b1, st);
        check_eq("t3_mty", 32'(o_mty), 3);
        check_eq("t3_slot0", 32'(o_dat[3:0]), 5);
        for (int w = 6; w <= 9; w++) send(4'(w), (w == 9), st);
        check_eq("t3_next_dat", 32'(o_dat), 32'h9876);
        idle(3);

        // 4: backpressure with a completing word waiting.
        o_rdy = 1'b0;
        for (int w = 1; w <= 4; w++) send(4'(w), 1'b0, st);
        i_dat = 4'h5;
        i_eop = 1'b1;
        i_val = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("t4_irdy_low", 32'(i_rdy), 0);
            check_eq("t4_hold_val", 32'(o_val), 1);
            check_eq("t4_hold_dat", 32'(o_dat), 32'h4321);
            check_eq("t4_hold_mty", 32'(o_mty), 0);
            check_eq("t4_hold_eop", 32'(o_eop), 0);
        end
        @(posedge clk);
        #1;
        o_rdy = 1'b1;
        @(negedge clk);
        check_eq("t4_irdy_up", 32'(i_rdy), 1);
        model_accept(4'h5, 1'b1);
        @(posedge clk);
        #1;
        i_val = 1'b0;
        i_eop = 1'b0;
        check_eq("t4_val_kept", 32'(o_val), 1);
        check_eq("t4_new_mty", 32'(o_mty), 3);
        check_eq("t4_new_eop", 32'(o_eop), 1);
        check_eq("t4_new_slot0", 32'(o_dat[3:0]), 5);
        idle(3);

        // 5: reset mid-packet discards the partial accumulation.
        send(4'h1, 1'b0, st);
        send(4'h2, 1'b0, st);
        do_reset();
        send(4'h9, 1'b0, st);
        send(4'hA, 1'b0, st);
        send(4'hB, 1'b0, st);
        send(4'hC, 1'b1, st);
        check_eq("t5_dat", 32'(o_dat), 32'hCBA9);
        check_eq("t5_mty", 32'(o_mty), 0);
        idle(3);

        // 6: full word followed by a single-word packet (slot 0 always checked).
        for (int w = 1; w <= 4; w++) send(4'(w), 1'b0, st);
        send(4'h7, 1'b1, st);
        check_eq("t6_mty", 32'(o_mty), 3);
        check_eq("t6_slot0", 32'(o_dat[3:0]), 7);

        // Drain: every expected word must have appeared.
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        idle(2);
        check_eq("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
